// File: rtl/l1a_check_sequencer_pkg.sv
// Shared types and defaults for the L1A alignment-check sequencer.
package l1a_check_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_DONE    = 3'd3,
    ST_RECOVER = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    RES_NONE     = 2'd0,
    RES_OK       = 2'd1,
    RES_MISMATCH = 2'd2,
    RES_TIMEOUT  = 2'd3
  } result_e;

  localparam int DEF_TIMEOUT        = 1024;
  localparam int DEF_RECOVER_CYCLES = 4;

  // Width needed to hold 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/l1a_check_sequencer_if.sv
// Link between the sequencer (master) and the per-OFC L1A alignment checker (slave).
interface l1a_check_sequencer_if #(
  parameter int N_OFC = 2
);

  logic [N_OFC-1:0] trig_in;
  logic             checker_finish;
  logic             checker_align;
  logic [N_OFC-1:0] checker_error;
  logic [N_OFC-1:0] start_check;
  logic             check_in_progress;
  logic             checker_reset;

  modport master (
    input  trig_in,
    input  checker_finish,
    input  checker_align,
    input  checker_error,
    output start_check,
    output check_in_progress,
    output checker_reset
  );

  modport slave (
    output trig_in,
    output checker_finish,
    output checker_align,
    output checker_error,
    input  start_check,
    input  check_in_progress,
    input  checker_reset
  );

endinterface

// File: rtl/l1a_check_sequencer_sat_counter.sv
// Saturating statistics counter; clear wins over a same-cycle increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/l1a_check_sequencer.sv
// Walks the L1A alignment checker through each OFC link, supervising every
// window with a timeout and recovering the checker after any failure.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | waiting for enable, checker window closed
//   ARM     | one cycle: window opened, OFC index and timer preset
//   WAIT    | start_check on current OFC, waiting for finish/error/timeout
//   DONE    | one cycle: sequence finished, result and counter published
//   RECOVER | checker_reset held for RECOVER_CYCLES after a failure
module l1a_check_sequencer
  import l1a_check_pkg::*;
#(
  parameter int N_OFC          = 2,
  parameter int TIMEOUT        = DEF_TIMEOUT,
  parameter int RECOVER_CYCLES = DEF_RECOVER_CYCLES,
  parameter int CNT_W          = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    clear_counters,
  l1a_check_sequencer_if.master   chk_if,
  output logic                    busy,
  output logic                    status_valid,
  output logic [1:0]              last_result,
  output logic [CNT_W-1:0]        align_count,
  output logic [CNT_W-1:0]        mismatch_count,
  output logic [CNT_W-1:0]        timeout_count
);

  localparam int IDX_W   = clog2_min1(N_OFC);
  localparam int TIMER_W = clog2_min1(TIMEOUT);
  localparam int REC_W   = clog2_min1(RECOVER_CYCLES);

  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_OFC - 1);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT - 1);
  localparam logic [REC_W-1:0]   REC_LOAD   = REC_W'(RECOVER_CYCLES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [REC_W-1:0]   rec_q, rec_d;
  result_e            last_result_q, last_result_d;
  logic               status_valid_q, status_valid_d;
  logic               busy_q, busy_d;
  logic [N_OFC-1:0]   start_check_q, start_check_d;
  logic               check_in_progress_q, check_in_progress_d;
  logic               checker_reset_q, checker_reset_d;
  logic               inc_align, inc_mismatch, inc_timeout;

  // The timer counts down from TIMEOUT-1; reaching zero is the same instant
  // an up-counting window timer would hit TIMEOUT-1.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    timer_d        = timer_q;
    rec_d          = rec_q;
    last_result_d  = last_result_q;
    status_valid_d = 1'b0;
    inc_align      = 1'b0;
    inc_mismatch   = 1'b0;
    inc_timeout    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_ARM;
      end

      ST_ARM: begin
        idx_d   = '0;
        timer_d = TIMER_LOAD;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        timer_d = timer_q - TIMER_W'(1);
        if (chk_if.trig_in[idx_q]) timer_d = TIMER_LOAD;

        if (chk_if.checker_finish && (idx_q != IDX_LAST)) begin
          idx_d   = idx_q + IDX_W'(1);
          timer_d = TIMER_LOAD;
        end else if (chk_if.checker_finish) begin
          state_d        = ST_DONE;
          status_valid_d = 1'b1;
          last_result_d  = chk_if.checker_align ? RES_OK : RES_MISMATCH;
          inc_align      = chk_if.checker_align;
          inc_mismatch   = !chk_if.checker_align;
        end else if (chk_if.checker_error[idx_q]) begin
          state_d        = ST_RECOVER;
          rec_d          = REC_LOAD;
          status_valid_d = 1'b1;
          last_result_d  = RES_MISMATCH;
          inc_mismatch   = 1'b1;
        end else if (timer_q == '0) begin
          state_d        = ST_RECOVER;
          rec_d          = REC_LOAD;
          status_valid_d = 1'b1;
          last_result_d  = RES_TIMEOUT;
          inc_timeout    = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = enable ? ST_ARM : ST_IDLE;
      end

      ST_RECOVER: begin
        if (rec_q == '0) begin
          state_d = enable ? ST_ARM : ST_IDLE;
        end else begin
          rec_d = rec_q - REC_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they register with it.
    busy_d              = (state_d != ST_IDLE);
    check_in_progress_d = (state_d == ST_ARM) || (state_d == ST_WAIT);
    start_check_d       = (state_d == ST_WAIT) ? (N_OFC'(1) << idx_d) : '0;
    checker_reset_d     = (state_d == ST_RECOVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q             <= ST_IDLE;
      idx_q               <= '0;
      timer_q             <= '0;
      rec_q               <= '0;
      last_result_q       <= RES_NONE;
      status_valid_q      <= 1'b0;
      busy_q              <= 1'b0;
      start_check_q       <= '0;
      check_in_progress_q <= 1'b0;
      checker_reset_q     <= 1'b0;
    end else begin
      state_q             <= state_d;
      idx_q               <= idx_d;
      timer_q             <= timer_d;
      rec_q               <= rec_d;
      last_result_q       <= last_result_d;
      status_valid_q      <= status_valid_d;
      busy_q              <= busy_d;
      start_check_q       <= start_check_d;
      check_in_progress_q <= check_in_progress_d;
      checker_reset_q     <= checker_reset_d;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_align_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_align),
    .clr   (clear_counters),
    .count (align_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_mismatch_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_mismatch),
    .clr   (clear_counters),
    .count (mismatch_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_timeout_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_timeout),
    .clr   (clear_counters),
    .count (timeout_count)
  );

  assign chk_if.start_check       = start_check_q;
  assign chk_if.check_in_progress = check_in_progress_q;
  assign chk_if.checker_reset     = checker_reset_q;
  assign busy                     = busy_q;
  assign status_valid             = status_valid_q;
  assign last_result              = last_result_q;

endmodule

// File: tb/tb_l1a_check_sequencer.sv
// Scoreboard bench for l1a_check_sequencer: stimulus pushes expected status
// records, a negedge monitor pops and compares them on every status_valid.
module tb_l1a_check_sequencer;

  localparam int N_OFC = 2;
  localparam int TMO   = 16;
  localparam int RECC  = 4;
  localparam int CW    = 3;
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};

  logic clk;
  logic reset;
  logic enable;
  logic clear_counters;
  logic busy;
  logic status_valid;
  logic [1:0] last_result;
  logic [CW-1:0] align_count, mismatch_count, timeout_count;

  l1a_check_sequencer_if #(.N_OFC(N_OFC)) ifc ();

  l1a_check_sequencer #(
    .N_OFC(N_OFC), .TIMEOUT(TMO), .RECOVER_CYCLES(RECC), .CNT_W(CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .clear_counters (clear_counters),
    .chk_if         (ifc.master),
    .busy           (busy),
    .status_valid   (status_valid),
    .last_result    (last_result),
    .align_count    (align_count),
    .mismatch_count (mismatch_count),
    .timeout_count  (timeout_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    res;
    logic [CW-1:0] a;
    logic [CW-1:0] m;
    logic [CW-1:0] t;
  } exp_t;

  exp_t sb_q[$];
  int n_total = 0;
  int n_pass  = 0;
  logic [CW-1:0] m_a, m_m, m_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CMAX) ? v : v + CW'(1);
  endfunction

  task automatic push(input logic [1:0] res);
    exp_t e;
    e.res = res; e.a = m_a; e.m = m_m; e.t = m_t;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset && status_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_unexpected: got status_valid=1 last_result=%0d expected no pending result",
                 last_result);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_last_result", 32'(last_result), 32'(e.res));
        chk("sb_align_count", 32'(align_count), 32'(e.a));
        chk("sb_mismatch_count", 32'(mismatch_count), 32'(e.m));
        chk("sb_timeout_count", 32'(timeout_count), 32'(e.t));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start();
    int n = 0;
    while (ifc.start_check !== 2'b01 && n < 50) begin
      step();
      n++;
    end
    chk("wait_ofc0", 32'(ifc.start_check), 32'h1);
  endtask

  // Entered with OFC0 under check; finishes OFC0 then OFC1.
  task automatic finish_seq(input logic align_v, input logic clr);
    ifc.checker_finish = 1'b1;
    step();
    chk("advance_ofc1", 32'(ifc.start_check), 32'h2);
    ifc.checker_align = align_v;
    clear_counters    = clr;
    if (clr) begin
      m_a = '0; m_m = '0; m_t = '0;
    end else if (align_v) begin
      m_a = sat_inc(m_a);
    end else begin
      m_m = sat_inc(m_m);
    end
    push(align_v ? 2'd1 : 2'd2);
    step();
    ifc.checker_finish = 1'b0;
    ifc.checker_align  = 1'b0;
    clear_counters     = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_start_check"}, 32'(ifc.start_check), 32'h0);
    chk({tag, "_check_in_progress"}, 32'(ifc.check_in_progress), 32'h0);
    chk({tag, "_checker_reset"}, 32'(ifc.checker_reset), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_status_valid"}, 32'(status_valid), 32'h0);
    chk({tag, "_last_result"}, 32'(last_result), 32'h0);
    chk({tag, "_align_count"}, 32'(align_count), 32'h0);
    chk({tag, "_mismatch_count"}, 32'(mismatch_count), 32'h0);
    chk({tag, "_timeout_count"}, 32'(timeout_count), 32'h0);
  endtask

  task automatic run_timeout(input int trig_cycle, input logic [1:0] trig_val,
                             input int exp_n, input string nm);
    int n = 0;
    m_t = sat_inc(m_t);
    push(2'd3);
    while (status_valid !== 1'b1 && n < 60) begin
      if (n == trig_cycle) ifc.trig_in = trig_val;
      step();
      ifc.trig_in = '0;
      n++;
    end
    chk(nm, 32'(n), 32'(exp_n));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got no finish expected completion within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic bad;
    reset = 1'b1; enable = 1'b0; clear_counters = 1'b0;
    ifc.trig_in = '0; ifc.checker_finish = 1'b0;
    ifc.checker_align = 1'b0; ifc.checker_error = '0;
    m_a = '0; m_m = '0; m_t = '0;
    repeat (3) step();
    check_idle_outputs("reset");
    reset = 1'b0;
    step();

    // enable -> ARM -> WAIT: OFC0 selected two cycles later
    enable = 1'b1;
    step();
    chk("arm_start_check", 32'(ifc.start_check), 32'h0);
    chk("arm_check_in_progress", 32'(ifc.check_in_progress), 32'h1);
    chk("arm_busy", 32'(busy), 32'h1);
    step();
    chk("latency_ofc0", 32'(ifc.start_check), 32'h1);

    finish_seq(1'b1, 1'b0);

    // aligned=0 at the final finish: mismatch without recovery
    wait_start();
    finish_seq(1'b0, 1'b0);
    step();
    chk("rearm_no_reset", 32'(ifc.checker_reset), 32'h0);
    chk("rearm_cip", 32'(ifc.check_in_progress), 32'h1);
    step();
    chk("rearm_ofc0", 32'(ifc.start_check), 32'h1);

    // checker_error on OFC1
    ifc.checker_finish = 1'b1;
    step();
    ifc.checker_finish = 1'b0;
    chk("err_at_ofc1", 32'(ifc.start_check), 32'h2);
    ifc.checker_error = 2'b10;
    m_m = sat_inc(m_m);
    push(2'd2);
    step();
    ifc.checker_error = '0;
    n = 0; bad = 1'b0;
    while (ifc.checker_reset === 1'b1 && n < 20) begin
      if (ifc.check_in_progress !== 1'b0 || ifc.start_check !== 2'b00) bad = 1'b1;
      step();
      n++;
    end
    chk("recover_len", 32'(n), 32'(RECC));
    chk("recover_window_closed", 32'(bad), 32'h0);

    // timeouts: plain, trig on current OFC at cycle 10, trig on other OFC
    wait_start();
    run_timeout(-1, 2'b00, TMO, "timeout_plain");
    wait_start();
    run_timeout(10, 2'b01, 27, "timeout_trig0");
    wait_start();
    run_timeout(5, 2'b10, TMO, "timeout_trig_other");

    // finish coincident with terminal timer value wins, at both OFCs
    wait_start();
    repeat (TMO - 1) step();
    ifc.checker_finish = 1'b1;
    step();
    ifc.checker_finish = 1'b0;
    chk("finish_beats_tmo_idx", 32'(ifc.start_check), 32'h2);
    chk("finish_beats_tmo_rst", 32'(ifc.checker_reset), 32'h0);
    repeat (TMO - 1) step();
    ifc.checker_finish = 1'b1;
    ifc.checker_align  = 1'b1;
    m_a = sat_inc(m_a);
    push(2'd1);
    step();
    ifc.checker_finish = 1'b0;
    ifc.checker_align  = 1'b0;

    // clear_counters coincident with an align increment
    wait_start();
    finish_seq(1'b1, 1'b1);

    // enable dropped mid-sequence: finish, then IDLE
    wait_start();
    enable = 1'b0;
    finish_seq(1'b1, 1'b0);
    step();
    chk("drop_en_busy", 32'(busy), 32'h0);
    chk("drop_en_cip", 32'(ifc.check_in_progress), 32'h0);
    step();
    chk("drop_en_stays_idle", 32'(busy), 32'h0);

    // reset mid-WAIT
    enable = 1'b1;
    wait_start();
    reset = 1'b1;
    enable = 1'b0;
    step();
    check_idle_outputs("midreset");
    reset = 1'b0;
    m_a = '0; m_m = '0; m_t = '0;
    step();

    // saturation of align_count
    enable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wait_start();
      finish_seq(1'b1, 1'b0);
    end
    enable = 1'b0;
    step();
    chk("sat_align_count", 32'(align_count), 32'(CMAX));
    chk("sat_idle", 32'(busy), 32'h0);

    repeat (3) step();
    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
